// File: rtl/mon_chain_ctl.sv
// Sequencer and readout controller for a chain of two-channel CIC monitors:
// strobes samp every period, packs the tail word stream into a double-buffered frame.
module mon_chain_ctl #(
  parameter int RWI    = 28,
  parameter int NWORDS = 8,
  parameter int AW     = 3,
  parameter int CW     = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_enable,
  input  logic [CW-1:0]  i_period,
  output logic           o_samp,
  input  logic [RWI-1:0] i_s_chain,
  input  logic           i_g_chain,
  input  logic [AW-1:0]  i_rd_addr,
  output logic [RWI-1:0] o_rd_data,
  output logic           o_frame_ready,
  input  logic           i_frame_ack,
  output logic [7:0]     o_frame_seq,
  output logic           o_overrun,
  output logic           o_frame_err,
  input  logic           i_clear_err
);

  // state | meaning
  // IDLE  | sampling stopped, counter held at 0
  // PRIME | first period after enable; words counted, never published
  // RUN   | normal capture, frame closed at every samp

  localparam int              IW       = $clog2(NWORDS + 2);
  localparam logic [CW-1:0]   P_MIN    = CW'(NWORDS + 2);
  localparam logic [CW-1:0]   ONE_C    = CW'(1);
  localparam logic [IW-1:0]   IDX_FULL = IW'(NWORDS);
  localparam logic [IW-1:0]   IDX_SAT  = IW'(NWORDS + 1);
  localparam logic [AW:0]     RD_LIM   = (AW + 1)'(NWORDS);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t         r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt, r_per, w_per_in;
  logic [IW-1:0]  r_wr_idx, w_frame_cnt;
  logic           r_wsel, r_ready, r_ovr, r_err;
  logic [7:0]     r_seq;
  logic [RWI-1:0] r_rd_data;
  logic [RWI-1:0] r_bank [2][NWORDS];

  logic w_active, w_last, w_samp, w_close, w_inc, w_store;
  logic w_complete, w_publish, w_drop, w_bad;

  assign w_per_in = (i_period < P_MIN) ? P_MIN : i_period;
  assign w_last   = (r_cnt == r_per - ONE_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_active    = 1'b0;
    w_samp      = 1'b0;
    w_close     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_enable) w_state_nxt = PRIME;
      end
      PRIME: begin
        w_active = i_enable;
        w_samp   = i_enable && w_last;
        if (!i_enable)   w_state_nxt = IDLE;
        else if (w_samp) w_state_nxt = RUN;
      end
      RUN: begin
        w_active = i_enable;
        w_samp   = i_enable && w_last;
        w_close  = w_samp;
        if (!i_enable) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The word arriving in the strobe cycle still belongs to the frame being closed.
  assign w_inc       = w_active && i_g_chain && (r_wr_idx != IDX_SAT);
  assign w_store     = w_active && i_g_chain && (r_wr_idx < IDX_FULL);
  assign w_frame_cnt = w_inc ? r_wr_idx + IW'(1) : r_wr_idx;
  assign w_complete  = (w_frame_cnt == IDX_FULL);
  assign w_publish   = w_close && w_complete && (!r_ready || i_frame_ack);
  assign w_drop      = w_close && w_complete && r_ready && !i_frame_ack;
  assign w_bad       = w_close && !w_complete;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_per    <= P_MIN;
      r_wr_idx <= '0;
    end else if (!w_active) begin
      r_cnt    <= '0;
      r_per    <= w_per_in;
      r_wr_idx <= '0;
    end else if (w_samp) begin
      r_cnt    <= '0;
      r_per    <= w_per_in;
      r_wr_idx <= '0;
    end else begin
      r_cnt    <= r_cnt + ONE_C;
      r_wr_idx <= w_frame_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) r_bank[r_wsel][AW'(r_wr_idx)] <= i_s_chain;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wsel    <= 1'b0;
      r_ready   <= 1'b0;
      r_seq     <= '0;
      r_ovr     <= 1'b0;
      r_err     <= 1'b0;
      r_rd_data <= '0;
    end else begin
      if (w_publish) begin
        r_wsel  <= ~r_wsel;
        r_ready <= 1'b1;
        r_seq   <= r_seq + 8'd1;
      end else if (i_frame_ack) begin
        r_ready <= 1'b0;
      end
      if (w_drop)           r_ovr <= 1'b1;
      else if (i_clear_err) r_ovr <= 1'b0;
      if (w_bad)            r_err <= 1'b1;
      else if (i_clear_err) r_err <= 1'b0;
      r_rd_data <= ({1'b0, i_rd_addr} < RD_LIM) ? r_bank[~r_wsel][i_rd_addr] : '0;
    end
  end

  assign o_samp        = w_samp;
  assign o_rd_data     = r_rd_data;
  assign o_frame_ready = r_ready;
  assign o_frame_seq   = r_seq;
  assign o_overrun     = r_ovr;
  assign o_frame_err   = r_err;

endmodule

// File: doc/mon_chain_ctl.md
# mon_chain_ctl

Sequencer and readout controller for a daisy-chain of two-channel CIC monitor blocks. It generates the periodic `samp` strobe that ends each CIC integration period and captures the gated word stream that shifts out of the chain tail. It packs the words into a double-buffered frame memory and hands completed frames to a host with a ready/ack handshake, flagging drops and malformed frames. It sits between the monitor chain and the host register interface.

## Interface
- `rwi`, 28, result word width; matches the chain's stream width.
- `nwords`, 8, words per frame (2 × number of monitor blocks in the chain).
- `aw`, 3, readout address width; `2**aw >= nwords`.
- `cw`, 12, period counter width.

- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `enable`  in  1  level; run sampling when high.
- `period`  in  cw  clocks per CIC period P; sampled at each period wrap; values below nwords+2 are used as nwords+2.
- `samp`  out  1  one-cycle strobe to the chain's `samp` input.
- `s_chain`  in  rwi  signed stream from the chain tail `s_out`.
- `g_chain`  in  1  gate from the chain tail `g_out`.
- `rd_addr`  in  aw  host word index into the published frame.
- `rd_data`  out  rwi  word at `rd_addr`, registered.
- `frame_ready`  out  1  a published frame is readable.
- `frame_ack`  in  1  host pulse: published frame consumed.
- `frame_seq`  out  8  count of published frames, wraps at 255→0.
- `overrun`  out  1  sticky: complete frame dropped because previous frame not acked.
- `frame_err`  out  1  sticky: word count between strobes ≠ nwords.
- `clear_err`  in  1  clears `overrun` and `frame_err`.

## Operation
- Storage: two banks of nwords × rwi registers. One bank is the write bank, the other the read bank; `rd_data` always reads the read bank.
- States: IDLE, PRIME, RUN.
  - IDLE: counter=0, no `samp`. Go to PRIME when `enable`=1.
  - PRIME: the first period after enable. Gated words are counted but never published, because the integrators hold pre-enable history. Go to RUN at the first `samp`.
  - RUN: normal capture.
  - `enable`=0 in any state → IDLE next cycle. The partial frame is discarded. The read bank, `frame_ready`, and the sticky flags are preserved.
- Period counter counts 0..P-1. `samp`=1 in the cycle the counter equals P-1, then the counter wraps to 0.
- Capture: each cycle with `g_chain`=1 writes `s_chain` into the write bank at wr_idx, then wr_idx increments. The first gated word after a strobe goes to index 0.
- Gated words beyond nwords are not stored.
- At each `samp` in RUN, the frame collected since the previous `samp` is closed:
  - If wr_idx = nwords, the frame is complete. If `frame_ready`=0, or `frame_ack`=1 in this cycle, swap banks, set `frame_ready`=1 and increment `frame_seq`. Otherwise drop the frame and set `overrun`.
  - If wr_idx ≠ nwords (short or long), set `frame_err` and discard the frame.
  - wr_idx resets to 0 on every `samp`.
- `frame_ack` while `frame_ready`=1 clears `frame_ready` unless a swap occurs in the same cycle; a same-cycle swap leaves it at 1. `frame_ack` with `frame_ready`=0 is ignored.
- `clear_err` and a same-cycle set: set wins.

## Timing
- Reset values: `samp`=0, `rd_data`=0, `frame_ready`=0, `frame_seq`=0, `overrun`=0, `frame_err`=0, state IDLE, wr_idx=0, banks not cleared.
- First `samp` comes P cycles after the first cycle with `enable`=1 (counter 0..P-1). Subsequent strobes come every P cycles.
- A `period` change takes effect at the next wrap.
- Capture latency: `g_chain` in cycle n → word written at the edge ending cycle n.
- `frame_ready` rises in the cycle after the closing `samp`.
- `rd_data` is valid one cycle after `rd_addr` changes and one cycle after a swap.
- `rd_addr` ≥ nwords returns 0.

## Test plan
- nwords=4, P=10: enable; the chain returns 4 gated words 1 cycle after each `samp`. Required: the first `samp` at cycle 10 after enable, strobes at 10/20/30. The PRIME frame is not published. `frame_ready` rises after the second `samp` with words in order at rd_addr 0..3, and `frame_seq`=1.
- Host never acks; three complete frames arrive. Required: the first is published, and `overrun`=1 after the next close. The read bank still holds the first frame and `frame_seq` stays 1.
- `frame_ack` in the same cycle as a completing `samp`: new frame published, `frame_ready` stays 1, `overrun`=0, `frame_seq` increments.
- 3 gated words, then 5 gated words in successive periods. Required: `frame_err`=1 after each close, nothing published. `clear_err` then clears it to 0.
- `enable` dropped mid-frame after 2 words, re-enabled 7 cycles later. Required: `samp` stops, the partial frame is discarded, and the next `samp` comes P cycles after re-enable. The next frame is PRIME and not published.
- `rst_n` asserted mid-RUN with `frame_ready`=1: all outputs reach reset values asynchronously, with no `samp` until re-enable.
